// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen
// Brief    : IF-stage PC generator with predictor hookup and ID fetch queue.
// Revision : 1.0
// ============================================================================
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int          FQ_DEPTH    = 4,
    parameter int          FQ_PTR_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] bpu_pc,
    input  logic        bpu_taken,
    input  logic [31:0] bpu_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_pred_taken,
    output logic [31:0] id_pred_target,
    output logic [31:0] flush_count
);

    localparam logic [FQ_PTR_BITS:0] c_FQ_FULL = (FQ_PTR_BITS+1)'(FQ_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [31:0]            r_pc;
    logic [31:0]            r_pend_pc;
    logic                   r_pend_taken;
    logic [31:0]            r_pend_target;
    logic [31:0]            r_flush_count;
    logic [FQ_PTR_BITS-1:0] r_head;
    logic [FQ_PTR_BITS-1:0] r_tail;
    logic [FQ_PTR_BITS:0]   r_count;

    logic [31:0]            r_fq_pc     [FQ_DEPTH];
    logic [31:0]            r_fq_inst   [FQ_DEPTH];
    logic                   r_fq_taken  [FQ_DEPTH];
    logic [31:0]            r_fq_target [FQ_DEPTH];

    logic                   w_req_valid;
    logic                   w_hs;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_unused_redir_lsb;

    // Request gating depends only on registered state, never on id_ready.
    assign w_req_valid = (r_state == S_REQ) && (r_count < c_FQ_FULL);
    assign w_hs        = w_req_valid && imem_req_ready;
    assign w_push      = (r_state == S_WAIT) && imem_resp_valid && !ex_redirect;
    assign w_pop       = (r_count != '0) && id_ready && !ex_redirect;
    assign w_unused_redir_lsb = ^ex_redirect_pc[1:0];

    assign bpu_pc         = r_pc;
    assign imem_req_addr  = r_pc;
    assign imem_req_valid = w_req_valid;
    assign flush_count    = r_flush_count;
    assign id_valid       = (r_count != '0);
    assign id_pc          = r_fq_pc[r_head];
    assign id_inst        = r_fq_inst[r_head];
    assign id_pred_taken  = r_fq_taken[r_head];
    assign id_pred_target = r_fq_target[r_head];

    always_comb begin
        w_state_nxt = r_state;
        if (ex_redirect) begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_REQ;
                S_REQ:   w_state_nxt = w_hs ? S_DROP : S_REQ;
                S_WAIT:  w_state_nxt = imem_resp_valid ? S_REQ : S_DROP;
                S_DROP:  w_state_nxt = imem_resp_valid ? S_REQ : S_DROP;
                default: w_state_nxt = S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_REQ;
                S_REQ:   w_state_nxt = w_hs ? S_WAIT : S_REQ;
                S_WAIT:  w_state_nxt = imem_resp_valid ? S_REQ : S_WAIT;
                S_DROP:  w_state_nxt = imem_resp_valid ? S_REQ : S_DROP;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_pend_pc     <= '0;
            r_pend_taken  <= 1'b0;
            r_pend_target <= '0;
            r_flush_count <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_pend_pc     <= r_pc;
                r_pend_taken  <= bpu_taken;
                r_pend_target <= bpu_target;
            end
            if (ex_redirect) begin
                r_pc          <= {ex_redirect_pc[31:2], 2'b00};
                r_flush_count <= r_flush_count + 32'd1;
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
            end else begin
                if (w_hs) begin
                    r_pc <= bpu_taken ? bpu_target : r_pc + 32'd4;
                end
                if (w_push) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_pop) begin
                    r_head <= r_head + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Queue storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fq_pc[r_tail]     <= r_pend_pc;
            r_fq_inst[r_tail]   <= imem_resp_data;
            r_fq_taken[r_tail]  <= r_pend_taken;
            r_fq_target[r_tail] <= r_pend_target;
        end
    end

endmodule
`default_nettype wire
